m68k_bus_arbiter_decode: RTL and testbench

- Parametrised, registered successor to the combinational 68000 address decoder.
- Decodes the 68000 address into a one-hot region select from a parameter table, then runs a per-region wait-state/ready state machine.
- Generates DTACK_n and a bus-error timeout (BERR_n).
- Sits between the CPU core and all memory/peripheral blocks. A per-PCB region-enable mask replaces hard-coded per-board case arms.

---
 rtl/m68k_bus_arbiter_decode.sv | 187 ++++++++++++++++++
 tb/tb_m68k_bus_arbiter_decode.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_arbiter_decode.sv
// Registered 68000 region decoder: cs one edge after strobe, dtack_n after per-region waits/ext ready, berr_n on unmapped or timeout.
// Optional BUS_DECODE_ERRLOG_EN adds err_count/err_addr capture on every bus-error entry.
module m68k_bus_arbiter_decode #(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = 24,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {
    24'h180000, 24'h146000, 24'h144000, 24'h140000,
    24'h100000, 24'h0C0000, 24'h080000, 24'h000000},
  parameter logic [NUM_REGIONS*5-1:0] REGION_SHIFT = {
    5'd12, 5'd11, 5'd11, 5'd1, 5'd4, 5'd12, 5'd14, 5'd19},
  parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = {
    4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1},
  parameter logic [NUM_REGIONS-1:0] REGION_EXT = 8'b00000001,
  parameter int TIMEOUT = 255,
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      cpu_a,
  input  logic                   cpu_as_n,
  input  logic [NUM_REGIONS-1:0] region_en,
  input  logic [NUM_REGIONS-1:0] region_ready,
  output logic [NUM_REGIONS-1:0] cs,
  output logic [IDX_W-1:0]       hit_index,
  output logic                   dtack_n,
  output logic                   berr_n,
  output logic                   busy
`ifdef BUS_DECODE_ERRLOG_EN
  ,
  output logic [15:0]            err_count,
  output logic [ADDR_W-1:0]      err_addr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;

  state_t state, state_nxt;

  logic [NUM_REGIONS-1:0] hit;
  logic [IDX_W-1:0]       win_idx;
  logic                   any_hit;

  logic [3:0]             wait_cnt, wait_nxt;
  logic [7:0]             to_cnt, to_nxt;
  logic [NUM_REGIONS-1:0] cs_nxt;
  logic [IDX_W-1:0]       idx_nxt;
  logic                   dtack_nxt, berr_nxt;
  logic                   ack_ok, tmo;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit[i] = region_en[i] &&
               ((cpu_a >> REGION_SHIFT[i*5 +: 5]) ==
                (REGION_BASE[i*ADDR_W +: ADDR_W] >> REGION_SHIFT[i*5 +: 5]));
    end
  end

  // Scan downwards so the lowest hitting index is the last one written.
  always_comb begin
    win_idx = '0;
    any_hit = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_idx = IDX_W'(i);
        any_hit = 1'b1;
      end
    end
  end

  // hit_index holds the latched region for the whole bus cycle.
  assign ack_ok = (wait_cnt == 4'd0) && (!REGION_EXT[hit_index] || region_ready[hit_index]);
  assign tmo    = (to_cnt == 8'(TIMEOUT - 1));
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!cpu_as_n) state_nxt = any_hit ? S_WAIT : S_ERR;
      S_WAIT: begin
        if (cpu_as_n)    state_nxt = S_IDLE;
        else if (ack_ok) state_nxt = S_ACK;
        else if (tmo)    state_nxt = S_ERR;
      end
      S_ACK:  if (cpu_as_n) state_nxt = S_IDLE;
      S_ERR:  if (cpu_as_n) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cs_nxt    = cs;
    idx_nxt   = hit_index;
    dtack_nxt = dtack_n;
    berr_nxt  = berr_n;
    wait_nxt  = wait_cnt;
    to_nxt    = to_cnt;
    case (state)
      S_IDLE: begin
        if (!cpu_as_n) begin
          if (any_hit) begin
            cs_nxt   = NUM_REGIONS'(1) << win_idx;
            idx_nxt  = win_idx;
            wait_nxt = REGION_WAIT[int'(win_idx)*4 +: 4];
            to_nxt   = 8'd0;
          end else begin
            berr_nxt = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (cpu_as_n) begin
          cs_nxt = '0;
        end else begin
          wait_nxt = (wait_cnt != 4'd0) ? wait_cnt - 4'd1 : 4'd0;
          to_nxt   = to_cnt + 8'd1;
          if (ack_ok) begin
            dtack_nxt = 1'b0;
          end else if (tmo) begin
            cs_nxt   = '0;
            berr_nxt = 1'b0;
          end
        end
      end
      S_ACK: begin
        if (cpu_as_n) begin
          cs_nxt    = '0;
          dtack_nxt = 1'b1;
        end
      end
      S_ERR: begin
        if (cpu_as_n) berr_nxt = 1'b1;
      end
      default: begin
        cs_nxt    = '0;
        dtack_nxt = 1'b1;
        berr_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs        <= '0;
      hit_index <= '0;
      dtack_n   <= 1'b1;
      berr_n    <= 1'b1;
      wait_cnt  <= 4'd0;
      to_cnt    <= 8'd0;
    end else begin
      cs        <= cs_nxt;
      hit_index <= idx_nxt;
      dtack_n   <= dtack_nxt;
      berr_n    <= berr_nxt;
      wait_cnt  <= wait_nxt;
      to_cnt    <= to_nxt;
    end
  end

`ifdef BUS_DECODE_ERRLOG_EN
  logic [ADDR_W-1:0] a_q;
  logic              err_ev;

  assign err_ev = ((state == S_IDLE) && !cpu_as_n && !any_hit) ||
                  ((state == S_WAIT) && !cpu_as_n && !ack_ok && tmo);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      err_count <= 16'd0;
      err_addr  <= '0;
    end else begin
      if ((state == S_IDLE) && !cpu_as_n) a_q <= cpu_a;
      if (err_ev) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        err_addr <= (state == S_IDLE) ? cpu_a : a_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_m68k_bus_arbiter_decode.sv
// Directed bench for m68k_bus_arbiter_decode; region 4 is remapped onto 0x080000 to create an overlap with region 1.
module tb_m68k_bus_arbiter_decode;

  localparam logic [8*24-1:0] TB_BASE = {
    24'h180000, 24'h146000, 24'h144000, 24'h080000,
    24'h100000, 24'h0C0000, 24'h080000, 24'h000000};

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [23:0] cpu_a = 24'h0;
  logic        cpu_as_n = 1'b1;
  logic [7:0]  region_en = 8'hFF;
  logic [7:0]  region_ready = 8'h00;
  logic [7:0]  cs;
  logic [2:0]  hit_index;
  logic        dtack_n, berr_n, busy;
`ifdef BUS_DECODE_ERRLOG_EN
  logic [15:0] err_count;
  logic [23:0] err_addr;
`endif

  int n_checks = 0;
  int n_err = 0;

  m68k_bus_arbiter_decode #(.REGION_BASE(TB_BASE)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_as_n(cpu_as_n),
    .region_en(region_en), .region_ready(region_ready),
    .cs(cs), .hit_index(hit_index), .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy)
`ifdef BUS_DECODE_ERRLOG_EN
    , .err_count(err_count), .err_addr(err_addr)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [7:0] e_cs, input logic e_dt,
                         input logic e_be, input logic e_busy);
    chk({tag, ".cs"},    32'(cs),      32'(e_cs));
    chk({tag, ".dtack"}, 32'(dtack_n), 32'(e_dt));
    chk({tag, ".berr"},  32'(berr_n),  32'(e_be));
    chk({tag, ".busy"},  32'(busy),    32'(e_busy));
  endtask

  initial begin
    logic bad;
    #1 reset_n = 1'b0;
    #2;
    chk_bus("reset", 8'h00, 1'b1, 1'b1, 1'b0);
    chk("reset.idx", 32'(hit_index), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // ROM: one wait cycle, then external ready held off for 5 edges
    cpu_a = 24'h012345; cpu_as_n = 1'b0; region_ready = 8'h00;
    tick();
    chk_bus("rom.e0", 8'h01, 1'b1, 1'b1, 1'b1);
    chk("rom.idx", 32'(hit_index), 32'd0);
    bad = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (dtack_n !== 1'b1 || cs !== 8'h01) bad = 1'b1;
    end
    chk("rom.hold_no_ready", 32'(bad), 32'd0);
    region_ready = 8'h01;
    tick();
    chk_bus("rom.ack", 8'h01, 1'b0, 1'b1, 1'b1);
    cpu_as_n = 1'b1; region_ready = 8'h00;
    tick();
    chk_bus("rom.release", 8'h00, 1'b1, 1'b1, 1'b0);

    // ROM with ready already high: the wait cycle still delays dtack by one edge
    cpu_a = 24'h000100; cpu_as_n = 1'b0; region_ready = 8'h01;
    tick();
    chk_bus("romw.e0", 8'h01, 1'b1, 1'b1, 1'b1);
    tick();
    chk_bus("romw.e1", 8'h01, 1'b1, 1'b1, 1'b1);
    tick();
    chk_bus("romw.e2", 8'h01, 1'b0, 1'b1, 1'b1);
    cpu_as_n = 1'b1; region_ready = 8'h00;
    tick();
    chk_bus("romw.release", 8'h00, 1'b1, 1'b1, 1'b0);

    // RAM zero wait, strobe re-asserted with no gap cycle
    cpu_a = 24'h081FFE; cpu_as_n = 1'b0;
    tick();
    chk_bus("ram.e0", 8'h02, 1'b1, 1'b1, 1'b1);
    chk("ram.idx", 32'(hit_index), 32'd1);
    tick();
    chk_bus("ram.e1", 8'h02, 1'b0, 1'b1, 1'b1);
    cpu_as_n = 1'b1;
    tick();
    chk_bus("ram.release", 8'h00, 1'b1, 1'b1, 1'b0);

    // Unmapped just past the RAM window
    cpu_a = 24'h084000; cpu_as_n = 1'b0;
    tick();
    chk_bus("unmap1.e0", 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    chk_bus("unmap1.hold", 8'h00, 1'b1, 1'b0, 1'b1);
    cpu_as_n = 1'b1;
    tick();
    chk_bus("unmap1.release", 8'h00, 1'b1, 1'b1, 1'b0);

    // Shared RAM: two waits
    cpu_a = 24'h180FFE; cpu_as_n = 1'b0;
    tick();
    chk_bus("shr.e0", 8'h80, 1'b1, 1'b1, 1'b1);
    chk("shr.idx", 32'(hit_index), 32'd7);
    tick();
    chk("shr.e1.dtack", 32'(dtack_n), 32'd1);
    tick();
    chk("shr.e2.dtack", 32'(dtack_n), 32'd1);
    tick();
    chk_bus("shr.e3", 8'h80, 1'b0, 1'b1, 1'b1);
    cpu_as_n = 1'b1;
    tick();
    chk_bus("shr.release", 8'h00, 1'b1, 1'b1, 1'b0);

    cpu_a = 24'h181000; cpu_as_n = 1'b0;
    tick();
    chk_bus("unmap2.e0", 8'h00, 1'b1, 1'b0, 1'b1);
    cpu_as_n = 1'b1;
    tick();
    chk_bus("unmap2.release", 8'h00, 1'b1, 1'b1, 1'b0);

    // Masking: region 5 disabled gives bus error, region 2 still decodes
    region_en = 8'hDF; cpu_a = 24'h144010; cpu_as_n = 1'b0;
    tick();
    chk_bus("mask.r5", 8'h00, 1'b1, 1'b0, 1'b1);
    cpu_as_n = 1'b1;
    tick();
    cpu_a = 24'h0C0010; cpu_as_n = 1'b0;
    tick();
    chk_bus("mask.r2", 8'h04, 1'b1, 1'b1, 1'b1);
    tick();
    chk("mask.r2.dtack", 32'(dtack_n), 32'd0);
    cpu_as_n = 1'b1;
    tick();

    // Overlap of regions 1 and 4: lowest index wins
    region_en = 8'hFF; cpu_a = 24'h080001; cpu_as_n = 1'b0;
    tick();
    chk_bus("prio.both", 8'h02, 1'b1, 1'b1, 1'b1);
    chk("prio.both.idx", 32'(hit_index), 32'd1);
    tick();
    cpu_as_n = 1'b1;
    tick();
    region_en = 8'hFD; cpu_as_n = 1'b0;
    tick();
    chk_bus("prio.r4", 8'h10, 1'b1, 1'b1, 1'b1);
    chk("prio.r4.idx", 32'(hit_index), 32'd4);
    // Selection frozen after latch despite address and mask changes
    cpu_a = 24'h3FFFFF; region_en = 8'h00;
    tick();
    chk_bus("frozen", 8'h10, 1'b0, 1'b1, 1'b1);
    cpu_as_n = 1'b1; region_en = 8'hFF;
    tick();
    chk_bus("frozen.release", 8'h00, 1'b1, 1'b1, 1'b0);

    // Timeout on the external-ready region
    cpu_a = 24'h000200; cpu_as_n = 1'b0; region_ready = 8'h00;
    tick();
    chk_bus("tmo.e0", 8'h01, 1'b1, 1'b1, 1'b1);
    bad = 1'b0;
    for (int k = 1; k <= 254; k++) begin
      tick();
      if (berr_n !== 1'b1 || dtack_n !== 1'b1 || cs !== 8'h01) bad = 1'b1;
    end
    chk("tmo.before", 32'(bad), 32'd0);
    tick();
    chk_bus("tmo.e255", 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    chk("tmo.hold.berr", 32'(berr_n), 32'd0);
    cpu_as_n = 1'b1;
    tick();
    chk_bus("tmo.release", 8'h00, 1'b1, 1'b1, 1'b0);

    // Abort: strobe rises during the second wait cycle
    cpu_a = 24'h180010; cpu_as_n = 1'b0;
    tick();
    chk_bus("abort.e0", 8'h80, 1'b1, 1'b1, 1'b1);
    tick();
    cpu_as_n = 1'b1;
    tick();
    chk_bus("abort.e2", 8'h00, 1'b1, 1'b1, 1'b0);
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (dtack_n !== 1'b1 || berr_n !== 1'b1 || cs !== 8'h00) bad = 1'b1;
    end
    chk("abort.no_pulse", 32'(bad), 32'd0);

`ifdef BUS_DECODE_ERRLOG_EN
    chk("errlog.count", 32'(err_count), 32'd4);
    chk("errlog.addr", 32'(err_addr), 32'h000200);
`endif

    // Asynchronous reset while in ACK
    cpu_a = 24'h081000; cpu_as_n = 1'b0;
    tick();
    tick();
    chk_bus("rst.ack", 8'h02, 1'b0, 1'b1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_bus("rst.async", 8'h00, 1'b1, 1'b1, 1'b0);
    chk("rst.async.idx", 32'(hit_index), 32'd0);
`ifdef BUS_DECODE_ERRLOG_EN
    chk("rst.errlog.count", 32'(err_count), 32'd0);
`endif
    cpu_as_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    chk_bus("rst.after", 8'h00, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
